// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Number of bit groups walked per compare.
  function automatic int grp_count(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Counter must hold N itself, hence N+1 distinct values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_chain.sv
// 1-bit cascade comparator slice and the MSB-to-LSB chain of slices fed by the top.
module cascade_cmp_slice (
  input  logic a,
  input  logic b,
  input  logic lti,
  input  logic gti,
  output logic lt,
  output logic gt
);
  // A decision already made upstream dominates this bit.
  assign lt = lti | (~gti & ~a &  b);
  assign gt = gti | (~lti &  a & ~b);
endmodule

module comparator_cascade_chain #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [BITS_PER_CYCLE-1:0] ga,
  input  logic [BITS_PER_CYCLE-1:0] gb,
  input  logic                      lti,
  input  logic                      gti,
  output logic                      lt,
  output logic                      gt
);
  logic [BITS_PER_CYCLE:0] lt_c, gt_c;

  assign lt_c[0] = lti;
  assign gt_c[0] = gti;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
    cascade_cmp_slice u_slice (
      .a   (ga[BITS_PER_CYCLE-1-i]),
      .b   (gb[BITS_PER_CYCLE-1-i]),
      .lti (lt_c[i]),
      .gti (gt_c[i]),
      .lt  (lt_c[i+1]),
      .gt  (gt_c[i+1])
    );
  end

  assign lt = lt_c[BITS_PER_CYCLE];
  assign gt = gt_c[BITS_PER_CYCLE];
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, BITS_PER_CYCLE bits per RUN cycle.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing group is seen.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);
  localparam int N  = grp_count(WIDTH, BITS_PER_CYCLE);
  localparam int CW = cnt_width(N);
  localparam logic [WIDTH-1:0] SIGN_MSK = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide WIDTH evenly");
  end

  state_e           state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             lt_r, gt_r;
  logic             lt_nx, gt_nx;
  logic             finish;

  comparator_cascade_chain #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_chain (
    .ga  (sa[WIDTH-1 -: BITS_PER_CYCLE]),
    .gb  (sb[WIDTH-1 -: BITS_PER_CYCLE]),
    .lti (lt_r),
    .gti (gt_r),
    .lt  (lt_nx),
    .gt  (gt_nx)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign finish = (cnt == CW'(1)) | lt_nx | gt_nx;
`else
  assign finish = (cnt == CW'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      lt_r  <= 1'b0;
      gt_r  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping both sign bits maps two's-complement order onto unsigned order.
            sa    <= a ^ (SIGN_MSK & {WIDTH{is_signed}});
            sb    <= b ^ (SIGN_MSK & {WIDTH{is_signed}});
            cnt   <= CW'(N);
            lt_r  <= 1'b0;
            gt_r  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          lt_r <= lt_nx;
          gt_r <= gt_nx;
          sa   <= sa << BITS_PER_CYCLE;
          sb   <= sb << BITS_PER_CYCLE;
          cnt  <= cnt - CW'(1);
          if (finish) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            lt    <= lt_nx;
            gt    <= gt_nx;
            eq    <= ~(lt_nx | gt_nx);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed + randomized bench for serial_magnitude_comparator (BPC=1 and BPC=4 instances).
module tb_serial_magnitude_comparator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic        sgn_s   [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        lt_s    [2];
  logic        eq_s    [2];
  logic        gt_s    [2];
  logic [2:0]  last_res[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .is_signed(sgn_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .lt(lt_s[0]), .eq(eq_s[0]), .gt(gt_s[0]));

  serial_magnitude_comparator #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .is_signed(sgn_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .lt(lt_s[1]), .eq(eq_s[1]), .gt(gt_s[1]));

  // Reference: {lt,eq,gt} from plain integer comparison.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic l, g;
    if (s) begin
      l = $signed(a) < $signed(b);
      g = $signed(a) > $signed(b);
    end else begin
      l = a < b;
      g = a > b;
    end
    return {l, ~(l | g), g};
  endfunction

  // Reference latency: N groups, or the 1-based index of the first differing group when exiting early.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int bpc);
    int n = 32 / bpc;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    logic [31:0] diff = a ^ b;
    for (int i = 31; i >= 0; i--)
      if (diff[i]) return (31 - i) / bpc + 1;
`endif
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns half a cycle after the accepting edge.
  task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
    start_s[d] = 1'b1; a_s[d] = a; b_s[d] = b; sgn_s[d] = s;
    @(negedge clk);
    start_s[d] = 1'b0;
    check("busy_after_start", 32'(busy_s[d]), 32'd1);
  endtask

  task automatic wait_done(input int d, input int already, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
    int lat = already;
    bit stable = 1'b1;
    logic [2:0] r = ref_cmp(a, b, s);
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (done_s[d]) break;
      if ({lt_s[d], eq_s[d], gt_s[d]} !== last_res[d]) stable = 1'b0;
    end
    check("latency", 32'(lat), 32'(ref_lat(a, b, d ? 4 : 1)));
    check("result", 32'({lt_s[d], eq_s[d], gt_s[d]}), 32'(r));
    check("hold_while_busy", 32'(stable), 32'd1);
    check("busy_at_done", 32'(busy_s[d]), 32'd0);
    last_res[d] = r;
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
    start_op(d, a, b, s);
    wait_done(d, 0, a, b, s);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          saw_done;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; a_s[d] = '0; b_s[d] = '0; sgn_s[d] = 1'b0; last_res[d] = 3'b000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", 32'(busy_s[d]), 32'd0);
      check("reset_done", 32'(done_s[d]), 32'd0);
      check("reset_res", 32'({lt_s[d], eq_s[d], gt_s[d]}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases on BPC=1.
    run_op(0, 32'h0000_0005, 32'h0000_0009, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done_s[0]), 32'd0);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    run_op(0, 32'h8000_0000, 32'h0000_0000, 1'b0);
    run_op(0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);

    // Start mid-run with new operands must be ignored.
    start_op(0, 32'h1234_5678, 32'h1234_5678, 1'b0);
    repeat (5) @(negedge clk);
    start_s[0] = 1'b1; a_s[0] = 32'h0; b_s[0] = 32'h1; sgn_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0, 6, 32'h1234_5678, 32'h1234_5678, 1'b0);

    // Back-to-back: start issued in the done cycle.
    start_op(0, 32'h0000_0003, 32'h0000_0002, 1'b0);
    wait_done(0, 0, 32'h0000_0003, 32'h0000_0002, 1'b0);
    start_op(0, 32'h0000_0002, 32'h0000_0003, 1'b0);
    check("b2b_prev_held", 32'({lt_s[0], eq_s[0], gt_s[0]}), 32'(last_res[0]));
    wait_done(0, 0, 32'h0000_0002, 32'h0000_0003, 1'b0);

    // Randomized traffic on both widths of group.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0:       rb = $urandom;
        1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = ra;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(i % 2, ra, rb, rs);
    end

    // Reset in RUN cycle 10 aborts with no done pulse.
    start_op(0, 32'hAAAA_0000, 32'hAAAA_0001, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_s[0]), 32'd0);
    check("abort_res", 32'({lt_s[0], eq_s[0], gt_s[0]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res[0] = 3'b000;
    last_res[1] = 3'b000;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_s[0]) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_idle_res", 32'({lt_s[0], eq_s[0], gt_s[0]}), 32'd0);

    run_op(1, 32'h0000_00F0, 32'h0000_0F00, 1'b0);
    run_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(0, 32'h0000_0010, 32'h0000_0010, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator that feeds the 1-bit cascade comparator slice.
- Captures two WIDTH-bit operands and walks them MSB-first, BITS_PER_CYCLE bits per cycle.
- lt/gt cascade state is registered and fed back into the slice chain each cycle.
- Used by the MIPS ALU/branch path for slt/sltu/bgtz-style decisions where area matters more than latency.

Parameters:
- WIDTH, 32, operand width in bits.
- BITS_PER_CYCLE, 1, bits compared per RUN cycle; must divide WIDTH evenly (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- is_signed  input  1  1 = two's-complement compare; 0 = unsigned. Captured with operands.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when results become valid.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE; busy, done, lt, eq and gt all 0; shift registers and cascade registers cleared.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs return to their reset values.
- States: IDLE, RUN. N = WIDTH/BITS_PER_CYCLE; cnt is ceil(log2(N+1)) bits wide.
- Transitions:
  - IDLE + start: capture operands, go to RUN, busy=1, cnt=N, cascade lt_r=gt_r=0.
  - IDLE with no start: stay in IDLE.
  - RUN: each cycle, the top BITS_PER_CYCLE bits of the operand shift registers pass through the slice chain, MSB slice first.
    - Chain cascade inputs are lt_r/gt_r; chain outputs are written back to lt_r/gt_r.
    - Both shift registers shift left by BITS_PER_CYCLE; cnt decrements.
  - RUN with cnt==1: after this cycle's update, go to IDLE, busy=0, done=1 for one cycle.
    - lt = lt_r_next, gt = gt_r_next, eq = ~(lt_r_next | gt_r_next).
- Latency: start sampled at edge T; done and valid results are visible after edge T+N (done high for cycle T+N to T+N+1).
  - N RUN cycles, 1-cycle accept overhead folded in.
- Signed compare: at capture, the MSB of both a and b is inverted when is_signed=1. The rest of the datapath is identical.
- Invariant: lt and gt are mutually exclusive; exactly one of lt/eq/gt is 1 after any done.
- Results (lt/eq/gt) hold their value until the next done or reset.
- start while busy=1: ignored; operands not re-captured.
- start in the same cycle done=1: accepted (busy=0 then), giving back-to-back operations.
  - Results from the previous op remain stable until the new op's done.
- Once lt_r or gt_r is set, it stays set for the remainder of the operation (cascade-dominant slice semantics).

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: in RUN, if lt_r_next or gt_r_next is 1, terminate that cycle regardless of cnt.
  - done pulses and busy drops exactly as for cnt==1.
  - Latency becomes k cycles, where k is the index (1-based, MSB-first group) of the first differing bit group.
- Undefined: fixed latency of N cycles for every operation.

Decomposition:
- Shared package serial_cmp_pkg holds:
  - state enum (IDLE, RUN);
  - function computing N and counter width from WIDTH/BITS_PER_CYCLE.
- One natural sub-module: comparator_cascade_chain.
  - Purely structural: BITS_PER_CYCLE instances of the 1-bit cascade comparator slice, chained MSB to LSB.
  - Each slice's lt/gt feeds the next slice's lti/gti.
  - Inputs: bit groups plus cascade lt/gt. Outputs: final lt/gt.
- The top block holds the FSM, counter, shift registers and output registers.

Test Plan:
- Unsigned, WIDTH=32, BPC=1: a=0x0000_0005, b=0x0000_0009, is_signed=0 -> done after 32 cycles; lt=1, eq=0, gt=0.
- Signed: a=0xFFFF_FFFF (-1), b=0x0000_0001, is_signed=1 -> lt=1. Same operands with is_signed=0 -> gt=1.
- Equal operands a=b=0xDEAD_BEEF -> eq=1, lt=gt=0.
  - With SERIAL_CMP_EARLY_EXIT_EN defined, still 32 cycles.
- Early exit: a=0x8000_0000, b=0x0000_0000, unsigned, macro defined -> done 1 cycle after start, gt=1.
  - Macro undefined -> 32 cycles.
- Handshakes:
  - start pulsed mid-RUN with new operands -> ignored, original result reported.
  - start in the done cycle -> second result after a further N cycles with no idle gap.
- Reset at cycle 10 of RUN -> busy=0, done never pulses, lt=eq=gt=0.
  - Next start after reset completes correctly (BPC=4 config: N=8 cycles).
